// File: rtl/sram_arb_pkg.sv
// Shared helpers for the single-port SRAM round-robin arbiter.
package sram_arb_pkg;

  // Width of an index into n items, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of k among n requesters.
  function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin priority search starting at ptr, wrapping modulo NumReq.
module sram_rr_pick #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   gnt,
  output logic [IdxWidth-1:0] idx,
  output logic                valid
);

  logic [2*NumReq-1:0] w_dbl;
  int unsigned         w_sum;

  // Bit j of the rotated vector is requester (ptr + j) mod NumReq.
  assign w_dbl = {req, req} >> ptr;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_sum = 0;
    for (int j = 0; j < int'(NumReq); j++) begin
      if (!valid && w_dbl[j]) begin
        valid = 1'b1;
        w_sum = int'(ptr) + j;
        if (w_sum >= NumReq) w_sum = w_sum - NumReq;
        idx = IdxWidth'(w_sum);
      end
    end
    gnt = valid ? (NumReq'(1) << idx) : '0;
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters,
// routing read responses back Latency cycles after grant.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = idx_width(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned IdxWidth  = idx_width(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              we_i,
  input  logic [NumReq*AddrWidth-1:0]    addr_i,
  input  logic [NumReq*DataWidth-1:0]    wdata_i,
  input  logic [NumReq*BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [AddrWidth-1:0]           sram_addr_o,
  output logic [DataWidth-1:0]           sram_wdata_o,
  output logic [BeWidth-1:0]             sram_be_o,
  input  logic [DataWidth-1:0]           sram_rdata_i
);

  typedef struct packed {
    logic                valid;
    logic [IdxWidth-1:0] idx;
  } resp_stage_t;

  logic [IdxWidth-1:0] r_rr;
  logic [NumReq-1:0]   w_pick_gnt;
  logic [IdxWidth-1:0] w_pick_idx;
  logic                w_pick_valid;
  logic                w_grant;
  logic                w_rd_grant;
  logic                w_rsp_valid;
  logic [IdxWidth-1:0] w_rsp_idx;
  logic                w_rsp_live;

  sram_rr_pick #(
    .NumReq  (NumReq),
    .IdxWidth(IdxWidth)
  ) u_pick (
    .req  (req_i),
    .ptr  (r_rr),
    .gnt  (w_pick_gnt),
    .idx  (w_pick_idx),
    .valid(w_pick_valid)
  );

  // Reset forces the grant side idle even in the reset cycle itself.
  assign w_grant    = w_pick_valid & rst_ni;
  assign w_rd_grant = w_grant & ~we_i[w_pick_idx];
  assign gnt_o      = rst_ni ? w_pick_gnt : '0;

  assign sram_req_o   = w_grant;
  assign sram_we_o    = w_grant & we_i[w_pick_idx];
  assign sram_addr_o  = addr_i[int'(w_pick_idx)*AddrWidth +: AddrWidth];
  assign sram_wdata_o = wdata_i[int'(w_pick_idx)*DataWidth +: DataWidth];
  assign sram_be_o    = be_i[int'(w_pick_idx)*BeWidth +: BeWidth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_grant) begin
      r_rr <= IdxWidth'(rr_next(int'(w_pick_idx), NumReq));
    end
  end

  if (Latency == 0) begin : g_lat0
    assign w_rsp_valid = w_rd_grant;
    assign w_rsp_idx   = w_pick_idx;
  end else begin : g_pipe
    resp_stage_t r_pipe [Latency];

    // Shifts every cycle; new grants enter at the tail, stage 0 retires.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Latency); i++) r_pipe[i] <= '0;
      end else begin
        for (int i = 0; i < int'(Latency) - 1; i++) r_pipe[i] <= r_pipe[i+1];
        r_pipe[Latency-1] <= '{valid: w_rd_grant, idx: w_pick_idx};
      end
    end

    assign w_rsp_valid = r_pipe[0].valid;
    assign w_rsp_idx   = r_pipe[0].idx;
  end

  assign w_rsp_live = rst_ni & w_rsp_valid;
  assign rvalid_o   = w_rsp_live ? (NumReq'(1) << w_rsp_idx) : '0;
  assign rdata_o    = w_rsp_live ? sram_rdata_i : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench: three arbiter builds (Latency 1, 2, 0) on shared stimulus.
module tb_sram_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int ND = 3;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  idx;
    logic [63:0] data;
  } exp_t;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 0);
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0] tb_req;
  logic [NR-1:0] tb_we;
  logic [AW-1:0] tb_addr  [NR];
  logic [DW-1:0] tb_wdata [NR];
  logic [BW-1:0] tb_be    [NR];

  logic [NR*AW-1:0] addr_f;
  logic [NR*DW-1:0] wdata_f;
  logic [NR*BW-1:0] be_f;

  always_comb begin
    addr_f  = '0;
    wdata_f = '0;
    be_f    = '0;
    for (int i = 0; i < NR; i++) begin
      addr_f[i*AW +: AW]  = tb_addr[i];
      wdata_f[i*DW +: DW] = tb_wdata[i];
      be_f[i*BW +: BW]    = tb_be[i];
    end
  end

  logic [NR-1:0] gnt_a    [ND];
  logic [NR-1:0] rvalid_a [ND];
  logic [DW-1:0] rdata_a  [ND];
  logic          sreq_a   [ND];
  logic          swe_a    [ND];
  logic [AW-1:0] saddr_a  [ND];
  logic [DW-1:0] swdata_a [ND];
  logic [BW-1:0] sbe_a    [ND];
  logic [DW-1:0] srdata_a [ND];

  logic [DW-1:0] sram_mem [1024];
  logic [DW-1:0] ref_mem  [1024];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L = lat_of(g);
    sram_rr_arbiter #(
      .NumReq(NR), .NumWords(1024), .DataWidth(DW), .ByteWidth(8), .Latency(L)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(tb_req), .we_i(tb_we), .addr_i(addr_f), .wdata_i(wdata_f), .be_i(be_f),
      .gnt_o(gnt_a[g]), .rvalid_o(rvalid_a[g]), .rdata_o(rdata_a[g]),
      .sram_req_o(sreq_a[g]), .sram_we_o(swe_a[g]), .sram_addr_o(saddr_a[g]),
      .sram_wdata_o(swdata_a[g]), .sram_be_o(sbe_a[g]), .sram_rdata_i(srdata_a[g])
    );

    // Behavioural SRAM read path with this build's latency.
    logic [DW-1:0] rd_a = '0;
    logic [DW-1:0] rd_b = '0;
    always @(posedge clk) begin
      if (sreq_a[g] && !swe_a[g]) rd_a <= sram_mem[saddr_a[g]];
      rd_b <= rd_a;
    end
    if (L == 0) begin : g_l0
      assign srdata_a[g] = sram_mem[saddr_a[g]];
    end else if (L == 1) begin : g_l1
      assign srdata_a[g] = rd_a;
    end else begin : g_l2
      assign srdata_a[g] = rd_b;
    end
  end

  // Writes into the behavioural SRAM come from the first build's port.
  always @(posedge clk) begin
    if (sreq_a[0] && swe_a[0])
      for (int b = 0; b < BW; b++)
        if (sbe_a[0][b]) sram_mem[saddr_a[0]][b*8 +: 8] <= swdata_a[0][b*8 +: 8];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  exp_t          exp_q [ND][$];
  int            mptr = 0;
  int            wait_cnt [NR];
  logic [NR-1:0] gnt_seen = '0;

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [NR-1:0] eg;
    int            k;
    exp_t          e;
    eg = '0;
    k  = 0;
    if (rst_n) begin
      for (int j = 0; j < NR; j++) begin
        int c;
        c = (mptr + j) % NR;
        if (eg == '0 && tb_req[c]) begin
          eg = 4'(1) << c;
          k  = c;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("gnt[%0d]", d), 64'(gnt_a[d]), 64'(eg));
      chk($sformatf("sram_req[%0d]", d), 64'(sreq_a[d]), 64'(eg != '0));
    end
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) exp_q[d].delete();
      mptr = 0;
      for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (tb_req[i]) begin
          if (gnt_a[0][i]) begin
            chk($sformatf("fair[%0d]", i), 64'(wait_cnt[i] <= NR - 1), 64'd1);
            wait_cnt[i] = 0;
          end else begin
            wait_cnt[i]++;
          end
        end
      end
      if (eg != '0) begin
        if (!tb_we[k]) begin
          for (int d = 0; d < ND; d++) begin
            e.cyc  = 32'(cyc + 32'(lat_of(d)));
            e.idx  = 2'(k);
            e.data = ref_mem[tb_addr[k]];
            exp_q[d].push_back(e);
          end
        end else begin
          for (int b = 0; b < BW; b++)
            if (tb_be[k][b]) ref_mem[tb_addr[k]][b*8 +: 8] = tb_wdata[k][b*8 +: 8];
        end
        mptr = (k + 1) % NR;
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (exp_q[d].size() > 0 && exp_q[d][0].cyc == 32'(cyc)) begin
        e = exp_q[d].pop_front();
        chk($sformatf("rvalid[%0d]", d), 64'(rvalid_a[d]), 64'(4'(1) << e.idx));
        chk($sformatf("rdata[%0d]", d), rdata_a[d], e.data);
      end else begin
        chk($sformatf("rvalid_idle[%0d]", d), 64'(rvalid_a[d]), 64'd0);
        chk($sformatf("rdata_idle[%0d]", d), rdata_a[d], 64'd0);
      end
    end
    gnt_seen = gnt_a[0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [BW-1:0] be);
    tb_req[i]   = 1'b1;
    tb_we[i]    = we;
    tb_addr[i]  = a;
    tb_wdata[i] = wd;
    tb_be[i]    = be;
  endtask

  task automatic new_payload(input int i);
    load(i, 1'($urandom_range(1)), AW'($urandom_range(31)),
         {$urandom, $urandom}, BW'($urandom_range(255)));
  endtask

  // One cycle of random traffic; requests only drop or change after a grant.
  task automatic step(input int prob);
    tick();
    for (int i = 0; i < NR; i++) begin
      if (!tb_req[i] || gnt_seen[i]) begin
        if ($urandom_range(99) < 32'(prob)) new_payload(i);
        else tb_req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = {32'hC0DE_0000, 32'(i)};
      ref_mem[i]  = {32'hC0DE_0000, 32'(i)};
    end
    sram_mem[16] = 64'hA5;
    ref_mem[16]  = 64'hA5;
    rst_n  = 1'b0;
    tb_req = '0;
    tb_we  = '0;
    for (int i = 0; i < NR; i++) begin
      tb_addr[i] = '0; tb_wdata[i] = '0; tb_be[i] = '0;
      new_payload(i);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) step(100);
    repeat (6) step(0);

    load(2, 1'b0, AW'(16), '0, '0);
    tick();
    tb_req[2] = 1'b0;
    repeat (4) tick();

    load(1, 1'b1, AW'(5), 64'hDEAD_BEEF, 8'hFF);
    tick();
    tb_req[1] = 1'b0;
    load(3, 1'b0, AW'(5), '0, '0);
    tick();
    tb_req[3] = 1'b0;
    repeat (4) tick();

    load(0, 1'b0, AW'(9), '0, '0);
    tick();
    tb_req[0] = 1'b0;
    load(2, 1'b0, AW'(16), '0, '0);
    tick();
    tb_req[2] = 1'b0;
    repeat (4) tick();

    load(1, 1'b0, AW'(7), '0, '0);
    tick();
    tb_req[1] = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    load(0, 1'b0, AW'(3), '0, '0);
    load(3, 1'b0, AW'(4), '0, '0);
    repeat (5) step(0);

    repeat (300) step(60);
    repeat (10) step(0);
    repeat (4) tick();
    for (int d = 0; d < ND; d++)
      chk($sformatf("drain[%0d]", d), 64'(exp_q[d].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Round-robin arbiter that shares one port of a single-port `tc_sram` macro among `NumReq` requesters. It uses a per-requester req/gnt handshake and routes read responses back to the requester that issued them, `Latency` cycles after grant. It sits between cache/DMA-style clients and the SRAM instance, on the SRAM clock.

## Interface
- `NumReq`, 4: number of requesters (>= 1).
- `NumWords`, 1024: SRAM depth.
- `DataWidth`, 64: data width.
- `ByteWidth`, 8: byte width for byte enables.
- `Latency`, 1: SRAM read latency in cycles (>= 0). Must match the attached SRAM.
- `AddrWidth`, derived: `NumWords>1 ? $clog2(NumWords) : 1`.
- `BeWidth`, derived: `ceil(DataWidth/ByteWidth)`.
- `IdxWidth`, derived: `NumReq>1 ? $clog2(NumReq) : 1`.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_i`  in  NumReq  per-requester request.
- `we_i`  in  NumReq  per-requester write enable.
- `addr_i`  in  NumReq×AddrWidth  request address.
- `wdata_i`  in  NumReq×DataWidth  write data.
- `be_i`  in  NumReq×BeWidth  write byte enables.
- `gnt_o`  out  NumReq  one-hot grant; same cycle as accepted request.
- `rvalid_o`  out  NumReq  one-hot read-response valid.
- `rdata_o`  out  DataWidth  read data, broadcast to all requesters.
- `sram_req_o`, `sram_we_o`  out  1 each  SRAM request and write enable.
- `sram_addr_o`  out  AddrWidth  SRAM address.
- `sram_wdata_o`  out  DataWidth  SRAM write data.
- `sram_be_o`  out  BeWidth  SRAM byte enables.
- `sram_rdata_i`  in  DataWidth  SRAM read data.

## Operation
- State:
  - round-robin pointer `rr_q` (IdxWidth bits).
  - response pipeline of `Latency` stages, each stage `{valid, idx}`.
- Arbitration (combinational):
  - Search `req_i` starting at index `rr_q`, wrapping modulo NumReq.
  - The first set bit `k` wins. `gnt_o[k]=1`, `sram_req_o=1`.
  - The SRAM fields mux from requester `k`.
- Pointer update: on a grant to `k`, `rr_q <= (k+1) mod NumReq`. With no request, `rr_q` holds.
- Handshake:
  - A requester holds `req_i` and its payload stable until `gnt_o`.
  - The transfer completes in the `gnt` cycle.
  - `req_i` may drop only after grant.
  - Back-to-back grants to different or same requesters are allowed every cycle.
- Read response:
  - A read grant (`we_i[k]=0`) enters `{1,k}` at pipeline stage `Latency-1`.
  - When it reaches stage 0, `rvalid_o[k]=1` and `rdata_o=sram_rdata_i`.
  - Write grants enter `{0,x}` and never produce `rvalid`.
- `Latency==0`: `rvalid_o[k]` asserts in the grant cycle itself, with `rdata_o=sram_rdata_i` combinationally.
- `rdata_o` is 0 in any cycle with no `rvalid_o` bit set.
- Fairness: a requester holding `req_i` continuously is granted within NumReq cycles.
- Unmapped address (`addr_i >= NumWords`): forwarded unchanged. No check.

## Timing
- Reset (`rst_ni` low at posedge):
  - `rr_q <= 0`; all pipeline valid bits cleared.
  - While `rst_ni` is low, `gnt_o`, `sram_req_o`, `rvalid_o` and `rdata_o` are forced to 0. This applies combinationally in the reset cycle.
- Reset mid-operation: in-flight reads are dropped, and no `rvalid` follows for them after reset releases.
- Grant-to-rvalid latency is exactly `Latency` cycles.
  - Responses return in grant order.
  - At most one `rvalid` bit is set per cycle.
- Simultaneous events:
  - A new read grant and a response retiring in the same cycle are both served. The pipeline shifts every cycle regardless of grants.
  - A write grant in cycle t does not disturb a read response arriving in cycle t.
- `gnt_o` depends combinationally on `req_i` and `rr_q` only. There is no path from `sram_rdata_i` to `gnt_o`.
- No throughput bubbles: 100% SRAM utilisation under continuous requests.

## Structure
- Package `sram_arb_pkg` holds:
  - the `resp_stage_t` struct `{logic valid; logic [IdxWidth-1:0] idx;}`, as a parameterised typedef via the top;
  - helper function `rr_next(k, n)`.
- Sub-module `sram_rr_pick`: a pure combinational round-robin priority search. Inputs are `req`, `ptr`; outputs are one-hot `gnt`, `idx`, `valid`. It is reusable by other shared-memory arbiters.
- The top holds `rr_q`, the response pipeline, the payload mux and reset gating.

## Test plan
- Single requester: NumReq=4, Latency=1, req 2 reads addr 0x10 (SRAM preloaded 0xA5).
  - `gnt_o=4'b0100` same cycle.
  - `rvalid_o=4'b0100` and `rdata_o=0xA5` one cycle later.
  - No other rvalid.
- All four requesting continuously from reset:
  - grants go 0,1,2,3,0,… one per cycle;
  - each requester waits ≤ 4 cycles;
  - `sram_req_o` stays high every cycle.
- Mixed traffic:
  - Requester 1 writes 0xDEAD_BEEF (`be` all ones) to addr 5 in cycle t.
  - Requester 3 reads addr 5 in cycle t+1.
  - Expect `rvalid_o[3]` at t+2 with data 0xDEAD_BEEF, and no rvalid for requester 1.
- Latency=2 and Latency=0 builds:
  - reads from requesters 0 and 2 on consecutive cycles;
  - rvalids arrive in order exactly 2 (resp. 0) cycles after each grant.
- Reset mid-flight, Latency=2:
  - Read granted, then `rst_ni` low on the next posedge.
  - No `rvalid` ever appears for that read.
  - After release, `rr_q=0`, so a simultaneous request from 0 and 3 grants requester 0 first.
